// File: rtl/data_sram_responder.sv
// ============================================================================
// data_sram_responder
// ----------------------------------------------------------------------------
// Target side of the CPU's SRAM-like data port. Every cycle with i_en=1 is a
// request: i_wen=0000 reads, any strobe bit set writes. The addressed word
// (pre-write contents) appears on o_rdata after the next rising edge, so the
// CPU never stalls. Requests go either to a word-addressed RAM or to a small
// MMIO register bank (LED, SWITCH, TIMER, SCRATCH).
//
// Parameters
//   RAM_AW     RAM index width in words (2**RAM_AW x 32-bit words)
//   MMIO_BASE  base of the 64 KB MMIO window; only bits [31:16] are compared
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous reset, active-high
//   i_en         request valid this cycle
//   i_wen[3:0]   byte write strobes (0000 = read)
//   i_addr[31:0] byte address; bits [1:0] ignored
//   i_wdata[31:0] write data, lane i gated by i_wen[i]
//   o_rdata[31:0] registered read data, valid the cycle after the request
//   i_switch_in[7:0] asynchronous board switches
//   o_led_out[15:0]  LED register contents
// ============================================================================
module data_sram_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [3:0]  i_wen,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic [7:0]  i_switch_in,
    output logic [15:0] o_led_out
);

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_SCRATCH = 16'h000C;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] laneMerge(
        input logic [31:0] oldWord,
        input logic [31:0] newWord,
        input logic [3:0]  strobe
    );
        logic [31:0] merged;
        merged = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (strobe[i]) begin
                merged[8*i +: 8] = newWord[8*i +: 8];
            end
        end
        return merged;
    endfunction

    logic [31:0]       r_ram [2**RAM_AW];
    logic [31:0]       r_rdata;
    logic [15:0]       r_led;
    logic [31:0]       r_timer;
    logic [31:0]       r_scratch;
    logic [7:0]        r_swMeta;
    logic [7:0]        r_swSync;

    logic              w_mmioHit;
    logic [RAM_AW-1:0] w_ramIdx;
    logic [15:0]       w_off;
    logic              w_write;
    logic              w_ramWe;
    logic              w_ledWe;
    logic              w_timerWe;
    logic              w_scratchWe;
    logic [31:0]       w_mmioRdata;
    logic [31:0]       w_readData;

    // Address decode. Upper address bits outside the MMIO window are simply
    // ignored for RAM, so the RAM aliases throughout the rest of the space.
    assign w_mmioHit = (i_addr[31:16] == MMIO_BASE[31:16]);
    assign w_ramIdx  = i_addr[RAM_AW+1:2];
    assign w_off     = i_addr[15:0];

    // A request presented while reset is asserted must not write anything.
    assign w_write     = i_en && !i_rst && (i_wen != 4'b0000);
    assign w_ramWe     = w_write && !w_mmioHit;
    assign w_ledWe     = w_write && w_mmioHit && (w_off == OFF_LED);
    assign w_timerWe   = w_write && w_mmioHit && (w_off == OFF_TIMER);
    assign w_scratchWe = w_write && w_mmioHit && (w_off == OFF_SCRATCH);

    // MMIO read mux; everything is sampled before this cycle's updates, which
    // gives read-first behaviour and the pre-increment timer value.
    always_comb begin
        w_mmioRdata = 32'h0000_0000;
        case (w_off)
            OFF_LED:     w_mmioRdata = {16'h0000, r_led};
            OFF_SWITCH:  w_mmioRdata = {24'h00_0000, r_swSync};
            OFF_TIMER:   w_mmioRdata = r_timer;
            OFF_SCRATCH: w_mmioRdata = r_scratch;
            default:     w_mmioRdata = 32'h0000_0000;
        endcase
    end

    assign w_readData = w_mmioHit ? w_mmioRdata : r_ram[w_ramIdx];

    // RAM storage has no reset so its contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ramWe && i_wen[i]) begin
                r_ram[w_ramIdx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    // Registered read data; holds its value on idle cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= 32'h0000_0000;
        end else if (i_en) begin
            r_rdata <= w_readData;
        end
    end

    // LED register, only the low 16 bits exist.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_led <= 16'h0000;
        end else if (w_ledWe) begin
            if (i_wen[0]) begin
                r_led[7:0] <= i_wdata[7:0];
            end
            if (i_wen[1]) begin
                r_led[15:8] <= i_wdata[15:8];
            end
        end
    end

    // Free-running timer. A write replaces the increment for that cycle;
    // unwritten lanes keep the current (pre-increment) value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer <= 32'h0000_0000;
        end else if (w_timerWe) begin
            r_timer <= laneMerge(r_timer, i_wdata, i_wen);
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // General-purpose scratch register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scratch <= 32'h0000_0000;
        end else if (w_scratchWe) begin
            r_scratch <= laneMerge(r_scratch, i_wdata, i_wen);
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_swMeta <= 8'h00;
            r_swSync <= 8'h00;
        end else begin
            r_swMeta <= i_switch_in;
            r_swSync <= r_swMeta;
        end
    end

    assign o_rdata   = r_rdata;
    assign o_led_out = r_led;

endmodule

// File: tb/tb_data_sram_responder.sv
// ============================================================================
// tb_data_sram_responder
// ----------------------------------------------------------------------------
// Drives one request per clock into data_sram_responder and compares o_rdata
// and o_led_out against a behavioural model of the memory map (associative
// RAM array, plain register variables, cycle-counting timer).
// ============================================================================
module tb_data_sram_responder;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  switchIn;
   logic [15:0] ledOut;

   int assertCount;
   int failCount;

   // Reference model state
   logic [31:0] mRam [int];
   logic [15:0] mLed;
   logic [31:0] mTimer;
   logic [31:0] mScratch;
   logic [7:0]  mSwFirst;
   logic [7:0]  mSwSync;
   logic [31:0] expRdata;
   bit          expKnown;

   data_sram_responder #(
      .RAM_AW   (12),
      .MMIO_BASE(32'hBFAF_0000)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_wen      (wen),
      .i_addr     (addr),
      .i_wdata    (wdata),
      .o_rdata    (rdata),
      .i_switch_in(switchIn),
      .o_led_out  (ledOut)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  strobe);
      logic [31:0] res;
      res = oldWord;
      for (int i = 0; i < 4; i++) begin
         if (strobe[i]) res[8*i +: 8] = newWord[8*i +: 8];
      end
      return res;
   endfunction

   // One request cycle: update the model from the memory-map rules, drive the
   // inputs, then wait past the next rising edge.
   task automatic applyStimulus(input logic r, input logic e, input logic [3:0] w,
                                input logic [31:0] a, input logic [31:0] d);
      bit          isMmio;
      int          idx;
      logic [31:0] nextTimer;
      logic [31:0] tmp;
      isMmio = (a[31:16] == 16'hBFAF);
      idx    = int'(a[13:2]);
      if (r) begin
         expRdata = 32'h0;
         expKnown = 1'b1;
         mLed     = 16'h0;
         mTimer   = 32'h0;
         mScratch = 32'h0;
         mSwFirst = 8'h0;
         mSwSync  = 8'h0;
      end else begin
         nextTimer = mTimer + 32'd1;
         if (e) begin
            expKnown = 1'b1;
            if (!isMmio) begin
               if (mRam.exists(idx)) begin
                  expRdata = mRam[idx];
                  if (w != 4'b0) mRam[idx] = mergeBytes(mRam[idx], d, w);
               end else begin
                  expKnown = 1'b0;
                  if (w == 4'hF) mRam[idx] = d;
               end
            end else begin
               case (a[15:0])
                  16'h0000: begin
                     expRdata = {16'h0, mLed};
                     tmp  = mergeBytes({16'h0, mLed}, d, w);
                     mLed = tmp[15:0];
                  end
                  16'h0004: expRdata = {24'h0, mSwSync};
                  16'h0008: begin
                     expRdata = mTimer;
                     if (w != 4'b0) nextTimer = mergeBytes(mTimer, d, w);
                  end
                  16'h000C: begin
                     expRdata = mScratch;
                     mScratch = mergeBytes(mScratch, d, w);
                  end
                  default:  expRdata = 32'h0;
               endcase
            end
         end
         mTimer   = nextTimer;
         mSwSync  = mSwFirst;
         mSwFirst = switchIn;
      end
      rst   = r;
      en    = e;
      wen   = w;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare DUT outputs against the model after each request cycle.
   task automatic checkOutput(input string tag);
      if (expKnown) checkValue({tag, "_rdata"}, rdata, expRdata);
      checkValue({tag, "_led"}, {16'h0, ledOut}, {16'h0, mLed});
   endtask

   task automatic step(input string tag, input logic r, input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
      applyStimulus(r, e, w, a, d);
      checkOutput(tag);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] hi;
      logic [31:0] offs [7];
      assertCount = 0;
      failCount   = 0;
      expKnown    = 1'b0;
      expRdata    = 32'h0;
      mLed = 16'h0; mTimer = 32'h0; mScratch = 32'h0; mSwFirst = 8'h0; mSwSync = 8'h0;
      rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; switchIn = 8'h00;
      offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h2000};

      // Reset state
      step("reset0", 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      step("reset1", 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      checkValue("reset_rdata", rdata, 32'h0);
      checkValue("reset_led", {16'h0, ledOut}, 32'h0);

      // Fill RAM words 0..31 so later reads have defined contents
      for (int i = 0; i < 32; i++) begin
         step("init", 1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom);
      end

      // RAM write then read
      step("ram_wr", 1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF);
      step("ram_rd", 1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
      checkValue("ram_rw", rdata, 32'hDEAD_BEEF);

      // Byte strobes
      step("strb_wr", 1'b0, 1'b1, 4'hF, 32'h0000_0044, 32'h1122_3344);
      step("strb_part", 1'b0, 1'b1, 4'b0101, 32'h0000_0044, 32'hAABB_CCDD);
      step("strb_rd", 1'b0, 1'b1, 4'h0, 32'h0000_0044, 32'h0);
      checkValue("strobes", rdata, 32'h11BB_33DD);

      // Read-first, back-to-back, idle hold
      step("rf_init", 1'b0, 1'b1, 4'hF, 32'h0000_0048, 32'h0000_1234);
      step("rf_wr", 1'b0, 1'b1, 4'hF, 32'h0000_0048, 32'h0000_0005);
      checkValue("read_first", rdata, 32'h0000_1234);
      step("rf_rd", 1'b0, 1'b1, 4'h0, 32'h0000_0048, 32'h0);
      checkValue("b2b_read", rdata, 32'h0000_0005);
      step("idle", 1'b0, 1'b0, 4'hF, 32'hBFAF_000C, 32'hFFFF_FFFF);
      checkValue("idle_hold", rdata, 32'h0000_0005);

      // Timer counts from reset release
      step("t_rst0", 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      step("t_rst1", 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int i = 0; i < 10; i++) step("t_idle", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      step("t_rd10", 1'b0, 1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
      checkValue("timer_10", rdata, 32'd10);
      step("t_wr", 1'b0, 1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE);
      step("t_gap", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      step("t_rdA", 1'b0, 1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
      checkValue("timer_max", rdata, 32'hFFFF_FFFF);
      step("t_rdB", 1'b0, 1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
      checkValue("timer_wrap", rdata, 32'h0);

      // LED, switch, unmapped, read-only
      step("led_wr", 1'b0, 1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_1234);
      checkValue("led_out", {16'h0, ledOut}, 32'h0000_1234);
      step("led_rd", 1'b0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
      checkValue("led_read", rdata, 32'h0000_1234);
      switchIn = 8'hA5;
      step("sw_c0", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      step("sw_c1", 1'b0, 1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      step("sw_c2", 1'b0, 1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      checkValue("switch_sync", rdata, 32'h0000_00A5);
      step("unmap_rd", 1'b0, 1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
      checkValue("unmapped", rdata, 32'h0);
      step("sw_wr", 1'b0, 1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFF);
      step("sw_rd", 1'b0, 1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      checkValue("switch_ro", rdata, 32'h0000_00A5);

      // Reset with write requests pending
      step("rst_ram", 1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'h0BAD_0BAD);
      step("rst_led", 1'b1, 1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_FFFF);
      checkValue("rst_led_out", {16'h0, ledOut}, 32'h0);
      checkValue("rst_rdata", rdata, 32'h0);
      step("post_rst", 1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
      checkValue("ram_survives", rdata, 32'hDEAD_BEEF);

      // Randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) == 0) switchIn = 8'($urandom);
         if ($urandom_range(0, 99) < 55) begin
            hi = $urandom;
            if (hi[31:16] == 16'hBFAF) hi[31:16] = 16'h0000;
            a = {hi[31:14], 7'b0, 5'($urandom_range(0, 31)), 2'($urandom)};
         end else begin
            a = 32'hBFAF_0000 | offs[$urandom_range(0, 6)];
         end
         step("rand",
              ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
              ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
              a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
